fir_output_formatter: RTL



---
 rtl/fir_output_formatter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fir_output_formatter.sv
// fir_output_formatter
//   Rescales (round half toward +inf) and saturates the FIR bank output to
//   audio width. Results are buffered in a small FIFO, and one sample is
//   released per DAC sample_tick.
//   Pipeline: S1 (captured word) -> S2 (rounded/saturated) -> FIFO -> audio_out.
// Ports:
//   clock, reset_n             clock, async active-low reset
//   s_axis_tvalid/tready/tdata input stream from the active filter
//   sample_tick                single-cycle DAC sample request
//   audio_out                  current DAC sample (held between ticks)
//   audio_valid                pulse: audio_out was just reloaded from the FIFO
//   clip                       pulse: the S2 result was saturated
//   underflow                  pulse: tick arrived with the FIFO empty
//   fifo_level                 FIFO occupancy, 0..FIFO_DEPTH
module fir_output_formatter #(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 sample_tick,
  output logic [OUT_WIDTH-1:0] audio_out,
  output logic                 audio_valid,
  output logic                 clip,
  output logic                 underflow,
  output logic [ADDR_W:0]      fifo_level
);

  localparam int RW = ADDR_W + 2;

  // Half an LSB of the shifted result; evaluates to 0 when SHIFT == 0.
  localparam logic signed [IN_WIDTH:0] RND =
    signed'(({{IN_WIDTH{1'b0}}, 1'b1} << SHIFT) >> 1);
  localparam logic signed [IN_WIDTH:0] SAT_MAX =
    signed'({{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

  // vld_pipe[0] = S1 occupied, vld_pipe[1] = S2 occupied
  logic [1:0]                 vld_pipe;
  logic [IN_WIDTH-1:0]        s1_data;
  logic [OUT_WIDTH-1:0]       s2_data;
  logic [OUT_WIDTH-1:0]       mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]          wptr, rptr;

  logic                       accept, pop, wr;
  logic signed [IN_WIDTH:0]   rnd_sum, shifted;
  logic                       sat_hi, sat_lo;
  logic [OUT_WIDTH-1:0]       sat_val;
  logic [RW-1:0]              reserved_next;

  assign accept = s_axis_tvalid && s_axis_tready;
  assign wr     = vld_pipe[1];
  // The pop decision uses the level before this edge, so a word written on
  // the same edge is not visible to the tick.
  assign pop    = sample_tick && (fifo_level != '0);

  // Round and saturate S1 in IN_WIDTH+1 bits so the rounding add cannot wrap.
  always_comb begin
    rnd_sum = $signed({s1_data[IN_WIDTH-1], s1_data}) + RND;
    shifted = rnd_sum >>> SHIFT;
    sat_hi  = shifted > SAT_MAX;
    sat_lo  = shifted < SAT_MIN;
    sat_val = shifted[OUT_WIDTH-1:0];
    if (sat_hi)      sat_val = SAT_MAX[OUT_WIDTH-1:0];
    else if (sat_lo) sat_val = SAT_MIN[OUT_WIDTH-1:0];
  end

  // Occupancy after this edge: every accepted word holds a slot until popped,
  // so tready computed from this can never let the FIFO overflow.
  assign reserved_next = RW'(fifo_level) + RW'(vld_pipe[0]) + RW'(vld_pipe[1])
                       + RW'(accept) - RW'(pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe      <= '0;
      s1_data       <= '0;
      s2_data       <= '0;
      clip          <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      vld_pipe      <= {vld_pipe[0], accept};
      if (accept) s1_data <= s_axis_tdata;
      if (vld_pipe[0]) s2_data <= sat_val;
      clip          <= vld_pipe[0] && (sat_hi || sat_lo);
      s_axis_tready <= reserved_next < RW'(FIFO_DEPTH);
    end
  end

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge clock) begin
    if (wr) mem[wptr] <= s2_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr        <= '0;
      rptr        <= '0;
      fifo_level  <= '0;
      audio_out   <= '0;
      audio_valid <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) begin
        rptr      <= rptr + 1'b1;
        audio_out <= mem[rptr];
      end
      fifo_level  <= fifo_level + (ADDR_W+1)'(wr) - (ADDR_W+1)'(pop);
      audio_valid <= pop;
      underflow   <= sample_tick && (fifo_level == '0);
    end
  end

endmodule
